aes_round_seq: RTL and testbench
================================

# aes_round_seq

Iterative AES-128 encryption sequencer that owns one shared round-transform datapath (SubBytes/ShiftRows/MixColumns) and drives it through all rounds of a block. It performs the initial and per-round AddRoundKey itself, fetches round keys from an external round-key store by index, and presents a valid/ready stream interface upstream and downstream. A watchdog aborts the block if the multi-cycle S-box stage never signals completion.

## Interface
- NR, 10: number of rounds; round NR uses the ShiftRows-only result (no MixColumns).
- TIMEOUT, 64: maximum cycles spent in WAIT per round; 0 disables the watchdog.
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  sequencer can accept a block.
- in_block  input  128  plaintext.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts ciphertext.
- out_block  output  128  ciphertext; equals the state register.
- busy_o  output  1  high in every state except IDLE.
- err_o  output  1  one-cycle pulse on watchdog abort.
- rk_idx_o  output  4  round-key index; combinational from state and round.
- rk_i  input  128  round key for rk_idx_o, valid in the same cycle.
- rt_start_o  output  1  one-cycle start pulse to the round datapath.
- rt_b_o  output  128  round datapath input; equals the state register.
- rt_mc_i  input  128  datapath output after MixColumns.
- rt_sr_i  input  128  datapath output after ShiftRows (MixColumns bypassed).
- rt_done_i  input  1  datapath S-box completion pulse.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: in_ready=1, rk_idx_o=0. On in_valid&&in_ready: state <= in_block ^ rk_i, round <= 1, go to START.
- START: rt_start_o=1 for exactly one cycle, watchdog counter <= 0, go to WAIT. rt_done_i is ignored in START.
- WAIT: rk_idx_o=round. The counter increments each cycle. On rt_done_i:
  - round<NR: state <= rt_mc_i ^ rk_i, round <= round+1, go to START.
  - round==NR: state <= rt_sr_i ^ rk_i, go to DONE.
- Watchdog in WAIT: if TIMEOUT!=0, the counter reaches TIMEOUT, and rt_done_i is low, then err_o pulses, the block is discarded, and the FSM returns to IDLE. If rt_done_i and the timeout occur in the same cycle, rt_done_i wins.
- DONE: out_valid=1 and out_block held stable. When out_ready is high, go to IDLE. in_ready stays 0 in DONE; a new block is accepted one cycle after the handoff at the earliest.
- rt_b_o equals the state register and is stable from START until the capture in WAIT.
- in_valid outside IDLE is ignored and does not stall anything.
- round register width: $clog2(NR+1). Counter width: $clog2(TIMEOUT+1).
- rk_idx_o is zero-extended to 4 bits.

## Timing
- Reset values: in_ready=1, out_valid=0, busy_o=0, err_o=0, rt_start_o=0, rk_idx_o=0, and the state register, round and counter all 0 (so out_block=0 and rt_b_o=0). State is IDLE.
- Let L be the number of cycles from rt_start_o to rt_done_i, with L≥1.
- Each round takes L+1 cycles.
- With the accept edge at the end of cycle 0, out_valid first rises in cycle NR*(L+1)+1.
- Handoff completes on the first edge where out_valid&&out_ready. in_ready rises the following cycle.
- Asserting rst_n low mid-block aborts immediately with no err_o pulse. All outputs return to their reset values asynchronously.
- rt_start_o is never high in two consecutive cycles.

## Test plan
- FIPS-197 C.1: bench uses a real round datapath and an expanded key table for key 000102030405060708090a0b0c0d0e0f. Plaintext 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises in cycle 10*(L+1)+1 for both L=1 and L=3.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_block stay stable, in_ready=0, and a second in_valid is not accepted. Release -> handoff, then in_ready=1 the next cycle.
- Watchdog: TIMEOUT=8 and a stub that never raises rt_done_i -> err_o pulses exactly once 8 cycles after entering WAIT, then the FSM is in IDLE with busy_o=0 and no out_valid. Repeat with rt_done_i arriving on the timeout cycle -> no err_o, and the round advances.
- Reset mid-operation: drop rst_n in round 5 WAIT -> all outputs at reset values, no err_o. The next block after reset produces the correct FIPS-197 result.
- Round/key ordering: stub datapath with rt_mc_i=rt_b_o+1 and rt_sr_i=rt_b_o+2, and rk_i=rk_idx_o -> observed rk_idx_o sequence 0,1..10. Only the final capture uses rt_sr_i. out_block matches the bench model.
- Busy input: hold in_valid=1 with changing in_block throughout a block -> only the first value is encrypted. The next accept happens only after the handoff.

Source files
------------

// File: rtl/aes_round_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_round_seq
// Purpose  : Iterative AES-128 sequencer around a shared external round datapath.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_seq #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy_o,
    output logic         err_o,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic         rt_start_o,
    output logic [127:0] rt_b_o,
    input  logic [127:0] rt_mc_i,
    input  logic [127:0] rt_sr_i,
    input  logic         rt_done_i
);

    localparam int RW = $clog2(NR + 1);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [127:0]  blk;
    logic [127:0]  blk_nx;
    logic [RW-1:0] round;
    logic [RW-1:0] round_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          timeout;

    // With TIMEOUT == 0 the counter still runs but can never trip the abort.
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign timeout = (cnt == CW'(TIMEOUT));
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            blk   <= '0;
            round <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            blk   <= blk_nx;
            round <= round_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        blk_nx     = blk;
        round_nx   = round;
        cnt_nx     = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        err_o      = 1'b0;
        rt_start_o = 1'b0;
        rk_idx_o   = 4'(round);

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx_o = 4'd0;
                if (in_valid) begin
                    blk_nx   = in_block ^ rk_i;
                    round_nx = RW'(1);
                    state_nx = START;
                end
            end
            START: begin
                rt_start_o = 1'b1;
                cnt_nx     = '0;
                state_nx   = WAIT;
            end
            WAIT: begin
                cnt_nx = cnt + 1'b1;
                // Completion takes priority over a watchdog trip in the same cycle.
                if (rt_done_i) begin
                    if (round == RW'(NR)) begin
                        blk_nx   = rt_sr_i ^ rk_i;
                        state_nx = DONE;
                    end else begin
                        blk_nx   = rt_mc_i ^ rk_i;
                        round_nx = round + 1'b1;
                        state_nx = START;
                    end
                end else if (timeout) begin
                    err_o    = 1'b1;
                    state_nx = IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy_o    = (state != IDLE);
    assign out_block = blk;
    assign rt_b_o    = blk;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_seq
// Purpose  : Randomised bench with an AES-128 reference model and datapath model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_seq;

    localparam int TO = 8;
    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_block, out_block, rk_i, rt_b_o, rt_mc_i, rt_sr_i;
    logic         busy_o, err_o, rt_start_o, rt_done_i;
    logic [3:0]   rk_idx_o;

    // mode 0: real AES datapath, 1: arithmetic stub, 2: datapath never completes
    int           mode = 0;
    int           lat  = 1;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_err = 0;
    logic [7:0]   sbox [0:255];
    logic [127:0] rk_tab [0:15];
    logic         rec = 1'b0;
    logic [3:0]   last_rk = 4'd0;
    logic [3:0]   rkq [$];

    aes_round_seq #(.NR(10), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy_o(busy_o), .err_o(err_o), .rk_idx_o(rk_idx_o), .rk_i(rk_i),
        .rt_start_o(rt_start_o), .rt_b_o(rt_b_o), .rt_mc_i(rt_mc_i),
        .rt_sr_i(rt_sr_i), .rt_done_i(rt_done_i)
    );

    always #5 clk = ~clk;

    assign rk_i = (mode == 1) ? {124'd0, rk_idx_o} : rk_tab[rk_idx_o];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[127-8*(4*c+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic build_tables();
        logic [7:0]  inv;
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'd2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk_tab[r];
        return shift_rows(sub_bytes(s)) ^ rk_tab[10];
    endfunction

    function automatic logic [127:0] stub_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt;
        for (int r = 1; r < 10; r++) s = (s + 128'd1) ^ 128'(r);
        return (s + 128'd2) ^ 128'd10;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- round datapath model ----------------
    initial begin : dp_model
        int           dcnt;
        logic [127:0] cap;
        logic         prev_start;
        dcnt = 0; cap = '0; prev_start = 1'b0;
        rt_done_i = 1'b0; rt_mc_i = '0; rt_sr_i = '0;
        forever begin
            @(posedge clk); #1;
            rt_done_i = 1'b0;
            if (!rst_n) begin
                dcnt = 0;
                prev_start = 1'b0;
            end else begin
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0 && mode != 2) begin
                        check("rt_b_stable", rt_b_o, cap);
                        if (mode == 1) begin
                            rt_mc_i = cap + 128'd1;
                            rt_sr_i = cap + 128'd2;
                        end else begin
                            rt_sr_i = shift_rows(sub_bytes(cap));
                            rt_mc_i = mix_columns(rt_sr_i);
                        end
                        rt_done_i = 1'b1;
                    end
                end
                if (rt_start_o) begin
                    check("start_single", 128'(prev_start), 128'd0);
                    cap  = rt_b_o;
                    dcnt = lat;
                end
                prev_start = rt_start_o;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk); #2;
            if (err_o) n_err++;
            if (rec && rk_idx_o != last_rk) begin
                rkq.push_back(rk_idx_o);
                last_rk = rk_idx_o;
            end
        end
    end

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),   128'd1);
        check({tag, "_out_valid"}, 128'(out_valid),  128'd0);
        check({tag, "_busy"},      128'(busy_o),     128'd0);
        check({tag, "_err"},       128'(err_o),      128'd0);
        check({tag, "_start"},     128'(rt_start_o), 128'd0);
        check({tag, "_rk_idx"},    128'(rk_idx_o),   128'd0);
        check({tag, "_out_block"}, out_block,        128'd0);
        check({tag, "_rt_b"},      rt_b_o,           128'd0);
    endtask

    task automatic start_block(input logic [127:0] pt, input bit hold);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        check("in_ready_before_start", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_block = pt;
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out(input bit scramble, output int k);
        k = 1;
        while (!out_valid && k < 2000) begin
            if (scramble) in_block = rand128();
            tick();
            k++;
        end
        check("out_valid_seen", 128'(out_valid), 128'd1);
    endtask

    task automatic handoff();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("in_ready_after_handoff", 128'(in_ready), 128'd1);
        out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int           k, e0, pulses, errk;
        logic         busy_after;
        logic [127:0] pt, pt2;
        rst_n = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
        build_tables();
        repeat (3) @(posedge clk);
        #3;
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 at two datapath latencies; the second run also exercises backpressure
        for (int li = 0; li < 2; li++) begin
            lat = (li == 0) ? 1 : 3;
            e0  = n_err;
            start_block(FIPS_PT, 1'b0);
            wait_out(1'b0, k);
            check("fips_latency", 128'(k), 128'(10*(lat+1)+1));
            check("fips_ct", out_block, FIPS_CT);
            check("fips_no_err", 128'(n_err - e0), 128'd0);
            if (li == 0) handoff();
        end
        pt2 = rand128();
        in_valid = 1'b1;
        in_block = pt2;
        for (int c = 0; c < 20; c++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_block", out_block, FIPS_CT);
            check("bp_in_ready",  128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_handoff_ready", 128'(in_ready), 128'd1);
        check("bp_handoff_idle",  128'(busy_o),   128'd0);
        tick();
        in_valid = 1'b0;
        check("bp_second_accept", 128'(busy_o), 128'd1);
        wait_out(1'b0, k);
        check("bp_second_latency", 128'(k), 128'(10*(lat+1)+1));
        check("bp_second_ct", out_block, aes_ref(pt2));
        handoff();

        // random plaintexts, random latency, in_valid held with changing data
        for (int i = 0; i < 4; i++) begin
            lat = $urandom_range(1, TO);
            pt  = rand128();
            start_block(pt, 1'b1);
            wait_out(1'b1, k);
            check("rand_latency", 128'(k), 128'(10*(lat+1)+1));
            check("rand_ct", out_block, aes_ref(pt));
            handoff();
        end

        // stub datapath: key index order and final ShiftRows-only capture
        mode = 1;
        for (int i = 0; i < 3; i++) begin
            lat = $urandom_range(1, 4);
            pt  = rand128();
            rkq.delete();
            rkq.push_back(4'd0);
            last_rk = 4'd0;
            rec = 1'b1;
            start_block(pt, 1'b0);
            wait_out(1'b0, k);
            rec = 1'b0;
            check("stub_out", out_block, stub_ref(pt));
            check("stub_rk_count", 128'(rkq.size()), 128'd11);
            for (int j = 0; j < rkq.size() && j < 11; j++)
                check("stub_rk_seq", 128'(rkq[j]), 128'(j));
            handoff();
        end

        // watchdog: datapath never completes
        mode = 2;
        lat  = 1;
        pulses = 0; errk = 0; busy_after = 1'b1;
        start_block(rand128(), 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (err_o) begin pulses++; errk = c; end
            if (c == TO + 3) busy_after = busy_o;
            tick();
        end
        check("wd_pulses", 128'(pulses), 128'd1);
        check("wd_cycle", 128'(errk), 128'(TO + 2));
        check("wd_idle_busy", 128'(busy_after), 128'd0);
        check("wd_no_out_valid", 128'(out_valid), 128'd0);
        check("wd_in_ready", 128'(in_ready), 128'd1);

        // completion on the exact timeout cycle wins
        mode = 0;
        lat  = TO + 1;
        e0   = n_err;
        start_block(FIPS_PT, 1'b0);
        wait_out(1'b0, k);
        check("edge_latency", 128'(k), 128'(10*(lat+1)+1));
        check("edge_ct", out_block, FIPS_CT);
        check("edge_no_err", 128'(n_err - e0), 128'd0);
        handoff();

        // asynchronous reset during round 5 WAIT
        lat = 3;
        e0  = n_err;
        start_block(FIPS_PT, 1'b0);
        repeat (17) tick();
        check("mid_rk_idx", 128'(rk_idx_o), 128'd5);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        tick();
        check("midrst_no_err", 128'(n_err - e0), 128'd0);
        rst_n = 1'b1;
        tick();
        start_block(FIPS_PT, 1'b0);
        wait_out(1'b0, k);
        check("post_rst_latency", 128'(k), 128'(10*(lat+1)+1));
        check("post_rst_ct", out_block, FIPS_CT);
        handoff();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
